// File: rtl/uart_rx.sv
// uart_rx: receiver for an 11-bit serial frame.
// Frame layout: start (0), 8 data bits MSB first, parity, stop (1).
// The line is resynchronised through two flops, then sampled at the bit centre.
// Each completed frame, including errored ones, produces a one-cycle data_valid pulse.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line bit rate; CLK_FREQ/BAUD_RATE must be >= 8
//   PARITY     0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   rx          asynchronous serial input, idle high
//   data_out    last received byte
//   data_valid  one-cycle pulse; data_out/parity_err/frame_err are valid with it
//   parity_err  parity mismatch on the last frame
//   frame_err   stop bit sampled low on the last frame
//   rx_busy     high from start-edge detection until return to idle
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   When defined, each bit is the 2-of-3 majority of the samples taken at
//   centre-1, centre and centre+1. This delays the whole frame by one clock.
//
// States:
//   S_IDLE   | waiting for a falling edge on the synchronised line
//   S_START  | counting to the start-bit centre, rejecting false starts
//   S_DATA   | shifting in 8 data bits, MSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | sampling the stop bit and publishing the frame
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [31:0] BIT_TC = 32'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // The decision is made one clock late, so the centre+1 sample already exists.
  // Only the start wait is stretched. Later bits keep the same one-clock offset.
  localparam logic [31:0] HALF_TC = 32'(CLKS_PER_BIT / 2);
`else
  localparam logic [31:0] HALF_TC = 32'(CLKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        rx_s_q;
  logic        rx_prev_q;
  logic [31:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        par_bit_q;
  logic        bit_smp;
  logic        par_exp;

  // Reset the synchroniser to the idle level. This stops a reset from looking
  // like a start edge.
`ifdef UART_RX_MAJORITY_EN
  logic rx_prev2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_prev2_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      rx_prev_q  <= rx_s_q;
      rx_prev2_q <= rx_prev_q;
    end
  end

  assign bit_smp = (rx_s_q & rx_prev_q) | (rx_s_q & rx_prev2_q) | (rx_prev_q & rx_prev2_q);
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign bit_smp = rx_s_q;
`endif

  assign par_exp = (PARITY != 0) ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start needs a real high-to-low edge. A line stuck low after a
          // frame error therefore cannot start a new frame.
          if (rx_prev_q && !rx_s_q) begin
            state_q   <= S_START;
            rx_busy   <= 1'b1;
            clk_cnt_q <= '0;
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_TC) begin
            clk_cnt_q <= '0;
            if (bit_smp) begin
              state_q <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd7;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_TC) begin
            clk_cnt_q <= '0;
            shift_q   <= {shift_q[6:0], bit_smp};
            if (bit_cnt_q == 3'd0) begin
              state_q <= S_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q - 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        S_PARITY: begin
          if (clk_cnt_q == BIT_TC) begin
            clk_cnt_q <= '0;
            par_bit_q <= bit_smp;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop-bit, so a back-to-back start edge is still seen.
          if (clk_cnt_q == BIT_TC) begin
            clk_cnt_q  <= '0;
            data_out   <= shift_q;
            parity_err <= (par_bit_q != par_exp);
            frame_err  <= ~bit_smp;
            data_valid <= 1'b1;
            rx_busy    <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 10 clocks per bit.
// Two receivers share the rx line and the reset:
//   dut0  even parity
//   dut1  odd parity
module tb_uart_rx;

  localparam int CF  = 1000000;
  localparam int BR  = 100000;
  localparam int CPB = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;

  logic [7:0] d0_data, d1_data;
  logic       d0_dv, d1_dv, d0_perr, d1_perr, d0_ferr, d1_ferr, d0_busy, d1_busy;

  uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(d0_data), .data_valid(d0_dv), .parity_err(d0_perr),
    .frame_err(d0_ferr), .rx_busy(d0_busy)
  );

  uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(d1_data), .data_valid(d1_dv), .parity_err(d1_perr),
    .frame_err(d1_ferr), .rx_busy(d1_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pulse logs, sampled on the falling edge
  int         cyc = 0;
  int         nv0 = 0;
  int         nv1 = 0;
  int         v_cyc[0:31];
  logic [7:0] v_data[0:31];
  logic       v_perr[0:31];
  logic       v_ferr[0:31];
  logic       dv_prev   = 1'b0;
  logic       dv_wide   = 1'b0;
  logic       busy_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dv_prev <= d0_dv;
    if (d0_dv && dv_prev) dv_wide <= 1'b1;
    if (d0_busy) busy_seen <= 1'b1;
    if (d0_dv && nv0 < 32) begin
      v_cyc[nv0]  <= cyc;
      v_data[nv0] <= d0_data;
      v_perr[nv0] <= d0_perr;
      v_ferr[nv0] <= d0_ferr;
    end
    if (d0_dv) nv0 <= nv0 + 1;
    if (d1_dv) nv1 <= nv1 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic glitch);
    rx = b;
    if (glitch) begin
      tick(5);
      rx = ~b;
      tick(1);
      rx = b;
      tick(4);
    end else begin
      tick(CPB);
    end
  endtask

  int t_start = 0;

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gbit);
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], gbit == i);
    drive_bit(par, 1'b0);
    drive_bit(stp, 1'b0);
  endtask

  int n0, n1, lat;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("rst_data", d0_data, 8'h00);
    chk("rst_dv", d0_dv, 1'b0);
    chk("rst_perr", d0_perr, 1'b0);
    chk("rst_ferr", d0_ferr, 1'b0);
    chk("rst_busy", d0_busy, 1'b0);

    // 1: 0xA5, even parity bit 0
    n0 = nv0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      begin tick(50); chk("t1_busy_mid", d0_busy, 1'b1); end
    join
    tick(10);
    chk("t1_count", nv0 - n0, 1);
    chk("t1_data", d0_data, 8'hA5);
    chk("t1_perr", d0_perr, 1'b0);
    chk("t1_ferr", d0_ferr, 1'b0);
    chk("t1_busy", d0_busy, 1'b0);
    lat = v_cyc[nv0-1] - t_start;
    chk("t1_latency", (lat >= 106 && lat <= 110), 1'b1);

    // 2: parity checks
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    tick(10);
    chk("t2_3c_data", d0_data, 8'h3C);
    chk("t2_3c_perr", d0_perr, 1'b1);
    chk("t2_3c_ferr", d0_ferr, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, -1);
    tick(10);
    chk("t2_01p1_perr_even", d0_perr, 1'b0);
    chk("t2_01p1_perr_odd", d1_perr, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1, -1);
    tick(10);
    chk("t2_01p0_perr_odd", d1_perr, 1'b0);
    chk("t2_01p0_data_odd", d1_data, 8'h01);
    chk("t2_01p0_perr_even", d0_perr, 1'b1);

    // 3: 0x7E with stop low, then the line is held low
    n0 = nv0;
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(i != 7 && i != 0, 1'b0);
    drive_bit(1'b0, 1'b0);
    rx = 1'b0;
    tick(CPB + 30);
    rx = 1'b1;
    tick(30);
    chk("t3_count", nv0 - n0, 1);
    chk("t3_data", d0_data, 8'h7E);
    chk("t3_ferr", d0_ferr, 1'b1);
    chk("t3_perr", d0_perr, 1'b0);
    chk("t3_busy", d0_busy, 1'b0);

    // 4: 3-clock glitch on the idle line
    n0 = nv0;
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    chk("t4_busy_seen", busy_seen, 1'b1);
    chk("t4_busy_end", d0_busy, 1'b0);
    chk("t4_count", nv0 - n0, 0);
    chk("t4_data", d0_data, 8'h7E);
    chk("t4_ferr", d0_ferr, 1'b1);

    // 5: back-to-back frames
    n0 = nv0;
    send_frame(8'h00, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    tick(20);
    chk("t5_count", nv0 - n0, 3);
    chk("t5_d0", v_data[n0], 8'h00);
    chk("t5_d1", v_data[n0+1], 8'hFF);
    chk("t5_d2", v_data[n0+2], 8'h55);
    chk("t5_err", {v_perr[n0], v_ferr[n0], v_perr[n0+1], v_ferr[n0+1], v_perr[n0+2], v_ferr[n0+2]}, 6'b0);
    lat = v_cyc[n0+1] - v_cyc[n0];
    chk("t5_gap01", (lat >= 108 && lat <= 112), 1'b1);
    lat = v_cyc[n0+2] - v_cyc[n0+1];
    chk("t5_gap12", (lat >= 108 && lat <= 112), 1'b1);

    // 6: reset in the middle of the data bits of 0xC3
    n0 = nv0;
    n1 = nv1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    tick(3);
    rx = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_data", d0_data, 8'h00);
    chk("t6_rst_flags", {d0_dv, d0_perr, d0_ferr, d0_busy}, 4'b0);
    tick(CPB * 12);
    chk("t6_no_pulse", (nv0 - n0) + (nv1 - n1), 0);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    tick(10);
    chk("t6_count", nv0 - n0, 1);
    chk("t6_data", d0_data, 8'h81);
    chk("t6_perr", d0_perr, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    n0 = nv0;
    send_frame(8'h81, 1'b0, 1'b1, 4);
    tick(10);
    chk("t6_maj_count", nv0 - n0, 1);
    chk("t6_maj_data", d0_data, 8'h81);
    chk("t6_maj_perr", d0_perr, 1'b0);
`endif

    chk("dv_single_cycle", dv_wide, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
